inv_sub_bytes_stage: RTL and testbench
======================================

Name: inv_sub_bytes_stage

Overview:
Sequential InvShiftRows + InvSubBytes stage of the AES-128 inverse cipher round datapath. It accepts one 128-bit state over a valid/ready handshake and applies InvShiftRows on capture. It then substitutes the state BPC bytes per cycle through BPC instances of the byte inverse S-box lookup. The result is presented downstream (to AddRoundKey/InvMixColumns) over a second valid/ready handshake.

Parameters:
BPC, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; other values are a fatal elaboration error.
NGRP, 16/BPC (derived localparam), number of substitution cycles per block.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  upstream state valid.
in_ready  output  1  stage can accept a state.
in_state  input  128  state; [127:120] = byte 0 = s(0,0), byte i = s(i%4, i/4), column-major.
out_valid  output  1  result valid.
out_ready  input  1  downstream accepts the result.
out_state  output  128  InvSubBytes(InvShiftRows(in_state)), same byte order.
busy  output  1  high in BUSY or DONE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE, grp counter=0, out_valid=0, out_state=0, busy=0, in_ready=1. Reset asserted mid-block discards all work with no output.
- FSM states: IDLE, BUSY, DONE. in_ready = (state==IDLE). out_valid = (state==DONE). out_state is the working register.
- IDLE:
  - in_valid & in_ready: capture InvShiftRows(in_state) into the working register. Mapping is out s(r,c) = in s(r,(c-r) mod 4).
  - Then clear grp and go to BUSY.
- BUSY:
  - Each cycle, bytes [grp*BPC .. grp*BPC+BPC-1] of the working register are replaced by their inverse S-box value.
  - Byte lookup: high nibble = row index x, low nibble = column index y.
  - grp increments each cycle. When grp==NGRP-1, that cycle's substitution is the last and the next state is DONE with grp wrapping to 0.
- DONE: out_state is held stable until out_ready. DONE & out_ready returns to IDLE.
- Latency: capture edge T, then NGRP BUSY cycles; out_valid rises on edge T+NGRP. BPC=4 gives 4 cycles; BPC=16 gives 1 cycle.
- No overlap: a new state is accepted only in IDLE, at the cycle after the out handshake. Maximum throughput is one block per NGRP+2 cycles when out_ready is held high.
- in_valid during BUSY/DONE: ignored, no capture, upstream must hold. in_state may change freely when in_ready=0.
- out_ready while not DONE: ignored.
- Deassertion of out_ready: DONE persists indefinitely with out_state unchanged (full backpressure, no data loss).
- No combinational path from in_* to out_* and none from out_ready to in_ready. in_ready depends only on registered state.

Decomposition:
- Shared package aes_pkg:
  - state_t (128-bit)
  - byte index helper function byte_idx(row,col)=row+4*col
  - FSM enum {IDLE,BUSY,DONE}
  - localparam AES_NB=4
  - the InvShiftRows mapping function inv_shift_rows(state_t)
- Sub-module: the existing byte inverse S-box (nibble inputs x/y, 8-bit output), instantiated BPC times in a generate loop. Its inputs are driven from the bytes of the working register selected by grp.

Test Plan:
- FIPS-197 C.1 round 1, BPC=4: in_state=7ad5fda789ef4e272bca100b3d9ff59f -> out_state=bd6e7c3df2b5779e0b61216e8b10b689, out_valid exactly 4 cycles after the capture edge. Intermediate register after capture = 7a9f102789d5f50b2beffd9f3dca4ea7.
- Constant states: all bytes 0x00 -> all bytes 0x52; all bytes 0x63 -> all 0x00. Repeat for BPC=1 (latency 16) and BPC=16 (latency 1).
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_state stable, in_ready=0, a new in_valid pulse ignored. Then out_ready=1 -> IDLE next cycle and in_ready=1.
- Back-to-back: two FIPS vectors with in_valid held high and out_ready=1 -> both results in order, spaced NGRP+2 cycles apart, no drop or duplication.
- Reset mid-operation: assert rst_n=0 during BUSY grp=2 -> out_valid=0, out_state=0, in_ready=1 immediately (asynchronous). After release, the next block processes correctly.
- Random: 1000 random states with random out_ready stalls vs a reference model (InvShiftRows then byte table). All match; no out_valid without a prior capture.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES inverse-cipher types and helpers: state type, FSM encoding,
// byte indexing and the InvShiftRows byte permutation.
package aes_pkg;

  localparam int AES_NB = 4;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  // Column-major byte index of s(row,col): row + 4*col
  function automatic logic [3:0] byte_idx(input logic [1:0] row, input logic [1:0] col);
    return {col, row};
  endfunction

  // LSB position of byte idx inside a state (byte 0 sits in [127:120])
  function automatic logic [6:0] byte_pos(input logic [3:0] idx);
    return {~idx, 3'b000};
  endfunction

  // out s(r,c) = in s(r,(c-r) mod 4); the 2-bit subtraction wraps naturally
  function automatic state_t inv_shift_rows(input state_t s);
    state_t     res;
    logic [1:0] rr;
    logic [1:0] cc;
    res = '0;
    for (int r = 0; r < AES_NB; r++) begin
      for (int c = 0; c < AES_NB; c++) begin
        rr = 2'(r);
        cc = 2'(c);
        res[byte_pos(byte_idx(rr, cc)) +: 8] = s[byte_pos(byte_idx(rr, cc - rr)) +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/inv_sub_bytes_stage_inv_sbox.sv
// Byte inverse S-box: x selects the table row (high nibble), y the column.
module inv_sub_bytes_stage_inv_sbox (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] q
);

  logic [127:0] row_s;

  // Select one 16-entry row of the inverse S-box table
  always_comb begin
    case (x)
      4'h0:    row_s = 128'h52096ad53036a538bf40a39e81f3d7fb;
      4'h1:    row_s = 128'h7ce339829b2fff87348e4344c4dee9cb;
      4'h2:    row_s = 128'h547b9432a6c2233dee4c950b42fac34e;
      4'h3:    row_s = 128'h082ea16628d924b2765ba2496d8bd125;
      4'h4:    row_s = 128'h72f8f66486689816d4a45ccc5d65b692;
      4'h5:    row_s = 128'h6c704850fdedb9da5e154657a78d9d84;
      4'h6:    row_s = 128'h90d8ab008cbcd30af7e45805b8b34506;
      4'h7:    row_s = 128'hd02c1e8fca3f0f02c1afbd0301138a6b;
      4'h8:    row_s = 128'h3a9111414f67dcea97f2cfcef0b4e673;
      4'h9:    row_s = 128'h96ac7422e7ad3585e2f937e81c75df6e;
      4'ha:    row_s = 128'h47f11a711d29c5896fb7620eaa18be1b;
      4'hb:    row_s = 128'hfc563e4bc6d279209adbc0fe78cd5af4;
      4'hc:    row_s = 128'h1fdda8338807c731b11210592780ec5f;
      4'hd:    row_s = 128'h60517fa919b54a0d2de57a9f93c99cef;
      4'he:    row_s = 128'ha0e03b4dae2af5b0c8ebbb3c83539961;
      default: row_s = 128'h172b047eba77d626e169146355210c7d;
    endcase
  end

  // Column y: entry 0 sits in the top byte of the row
  assign q = row_s[{~y, 3'b000} +: 8];

endmodule

// File: rtl/inv_sub_bytes_stage.sv
// InvShiftRows on capture, then InvSubBytes BPC bytes per cycle, with
// valid/ready handshakes on both sides and no overlap between blocks.
module inv_sub_bytes_stage
  import aes_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int NGRP = 16 / BPC;
  localparam int GW   = (NGRP > 1) ? $clog2(NGRP) : 1;

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bpc_check
    $fatal(1, "inv_sub_bytes_stage: BPC must be 1, 2, 4, 8 or 16");
  end

  fsm_e             state_r;
  fsm_e             state_nx_s;
  logic [GW-1:0]    grp_r;
  logic [GW-1:0]    grp_nx_s;
  state_t           work_r;
  state_t           work_nx_s;
  state_t           subst_s;
  logic [3:0]       grp_base_s;
  logic             last_grp_s;
  logic [8*BPC-1:0] sel_s;
  logic [8*BPC-1:0] sub_s;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             busy_r;

  assign grp_base_s = 4'(grp_r * BPC);
  assign last_grp_s = (grp_r == GW'(NGRP - 1));

  // One inverse S-box per lane, fed from the bytes of the current group
  for (genvar j = 0; j < BPC; j++) begin : g_lane
    assign sel_s[8*j +: 8] = work_r[byte_pos(grp_base_s + 4'(j)) +: 8];
    inv_sub_bytes_stage_inv_sbox u_sbox (
      .x (sel_s[8*j+4 +: 4]),
      .y (sel_s[8*j +: 4]),
      .q (sub_s[8*j +: 8])
    );
  end

  // Byte b belongs to group b/BPC and is served by lane b%BPC
  for (genvar b = 0; b < 16; b++) begin : g_byte
    localparam int         LANE = b % BPC;
    localparam logic [6:0] POS  = 7'((15 - b) * 8);
    assign subst_s[POS +: 8] = (grp_r == GW'(b / BPC)) ? sub_s[8*LANE +: 8] : work_r[POS +: 8];
  end

  // Next-state, group counter and working-register update
  always_comb begin
    state_nx_s = state_r;
    grp_nx_s   = grp_r;
    work_nx_s  = work_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          work_nx_s  = inv_shift_rows(in_state);
          grp_nx_s   = '0;
          state_nx_s = BUSY;
        end else begin
          state_nx_s = IDLE;
        end
      end
      BUSY: begin
        work_nx_s = subst_s;
        if (last_grp_s) begin
          grp_nx_s   = '0;
          state_nx_s = DONE;
        end else begin
          grp_nx_s   = grp_r + GW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: begin
        grp_nx_s   = '0;
        state_nx_s = IDLE;
      end
    endcase
  end

  // State registers; handshake flags are registered decodes of the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      grp_r       <= '0;
      work_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      grp_r       <= grp_nx_s;
      work_r      <= work_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      busy_r      <= (state_nx_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_state = work_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_inv_sub_bytes_stage.sv
// Scoreboard bench for inv_sub_bytes_stage at BPC = 1, 4 and 16.
module tb_inv_sub_bytes_stage;

  localparam logic [127:0] FIPS_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] FIPS_MID = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
  localparam logic [127:0] FIPS_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
  localparam logic [127:0] ALL_00   = 128'h0;
  localparam logic [127:0] ALL_52   = {16{8'h52}};
  localparam logic [127:0] ALL_63   = {16{8'h63}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] in_state = '0;
  logic [2:0]   in_valid = 3'b000;
  logic [2:0]   out_ready = 3'b111;
  logic [2:0]   in_ready_w;
  logic [2:0]   out_valid_w;
  logic [2:0]   busy_w;
  logic [127:0] out_state_w [3];

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  bit  b2b_mode = 1'b0;
  bit  rand_mode = 1'b0;
  logic [7:0] isb [256];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Independent reference: forward S-box from GF(2^8) inverse + affine map
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_table();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h01;
      for (int e = 0; e < 254; e++) inv = gmul(inv, 8'(a));
      if (a == 0) inv = 8'h00;
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      isb[s] = 8'(a);
    end
  endtask

  function automatic logic [127:0] ref_model(input logic [127:0] st);
    logic [127:0] res = '0;
    logic [7:0]   b;
    int           src;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = r + 4 * ((c - r + 4) % 4);
        b   = 8'(st >> (8 * (15 - src)));
        res = res | (128'(isb[b]) << (8 * (15 - (r + 4 * c))));
      end
    end
    return res;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int B  = (k == 0) ? 1 : ((k == 1) ? 4 : 16);
    localparam int NG = 16 / B;

    inv_sub_bytes_stage #(.BPC(B)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[k]),
      .in_ready  (in_ready_w[k]),
      .in_state  (in_state),
      .out_valid (out_valid_w[k]),
      .out_ready (out_ready[k]),
      .out_state (out_state_w[k]),
      .busy      (busy_w[k])
    );

    logic [127:0] exp_q [$];
    int           cap_q [$];
    bit           seen = 1'b0;
    bit           popped = 1'b0;
    logic [127:0] held = '0;
    int           last_rise = -1;

    // Record the cycle number of every accepted capture
    always @(posedge clk) begin
      if (rst_n && in_valid[k] && in_ready_w[k]) cap_q.push_back(cyc + 1);
    end

    // Monitor: compare each presented result against the scoreboard
    always @(negedge clk) begin
      if (!rst_n) begin
        exp_q.delete();
        cap_q.delete();
        seen = 1'b0;
        popped = 1'b0;
        last_rise = -1;
      end else begin
        if (popped) begin
          check($sformatf("in_ready_after_out_b%0d", B), 128'(in_ready_w[k]), 128'd1);
          check($sformatf("out_valid_after_out_b%0d", B), 128'(out_valid_w[k]), 128'd0);
          popped = 1'b0;
        end
        if (out_valid_w[k]) begin
          check($sformatf("in_ready_in_done_b%0d", B), 128'(in_ready_w[k]), 128'd0);
          check($sformatf("busy_in_done_b%0d", B), 128'(busy_w[k]), 128'd1);
          if (!seen) begin
            seen = 1'b1;
            held = out_state_w[k];
            if (exp_q.size() == 0 || cap_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL spurious_out_valid_b%0d: got out_state %h with no capture pending", B, out_state_w[k]);
            end else begin
              check($sformatf("latency_b%0d", B), 128'(cyc - cap_q[0]), 128'(NG));
              check($sformatf("data_b%0d", B), out_state_w[k], exp_q[0]);
            end
            if (b2b_mode) begin
              if (last_rise >= 0) check($sformatf("b2b_spacing_b%0d", B), 128'(cyc - last_rise), 128'(NG + 2));
              last_rise = cyc;
            end else begin
              last_rise = -1;
            end
          end else begin
            check($sformatf("hold_stable_b%0d", B), out_state_w[k], held);
          end
          if (out_ready[k]) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            if (cap_q.size() > 0) void'(cap_q.pop_front());
            seen = 1'b0;
            popped = 1'b1;
          end
        end
      end
    end
  end

  task automatic push_exp(input int k, input logic [127:0] ex);
    case (k)
      0:       g[0].exp_q.push_back(ex);
      1:       g[1].exp_q.push_back(ex);
      default: g[2].exp_q.push_back(ex);
    endcase
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return g[0].exp_q.size();
      1:       return g[1].exp_q.size();
      default: return g[2].exp_q.size();
    endcase
  endfunction

  // Present a state, wait (bounded) for acceptance, return just after the capture edge
  task automatic send(input int k, input logic [127:0] st, input logic [127:0] ex, input bit hold);
    int n = 0;
    in_state = st;
    in_valid[k] = 1'b1;
    while (!in_ready_w[k] && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout_k%0d: in_ready stayed %b, required 1", k, in_ready_w[k]);
    end else begin
      push_exp(k, ex);
    end
    tick();
    if (!hold) in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (qsize(k) != 0 && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout_k%0d: %0d results pending, required 0", k, qsize(k));
    end
    tick();
  endtask

  // Random downstream stalls on the BPC=4 instance
  always @(posedge clk) begin
    if (rand_mode) begin
      #2;
      out_ready[1] = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [127:0] r;
    int n;
    build_table();
    repeat (3) tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_out_valid_k%0d", k), 128'(out_valid_w[k]), 128'd0);
      check($sformatf("rst_out_state_k%0d", k), out_state_w[k], 128'd0);
      check($sformatf("rst_in_ready_k%0d", k), 128'(in_ready_w[k]), 128'd1);
      check($sformatf("rst_busy_k%0d", k), 128'(busy_w[k]), 128'd0);
    end
    rst_n = 1'b1;
    tick();

    // FIPS-197 round-1 vector; intermediate register visible right after capture
    send(1, FIPS_IN, FIPS_OUT, 1'b0);
    check("fips_after_inv_shift_rows", out_state_w[1], FIPS_MID);
    drain(1);

    // Constant states and FIPS on every width
    for (int k = 0; k < 3; k++) begin
      send(k, ALL_00, ALL_52, 1'b0);
      drain(k);
      send(k, ALL_63, ALL_00, 1'b0);
      drain(k);
      send(k, FIPS_IN, FIPS_OUT, 1'b0);
      drain(k);
    end

    // Backpressure: hold DONE for 10 cycles, ignored in_valid pulse meanwhile
    out_ready[1] = 1'b0;
    send(1, FIPS_IN, FIPS_OUT, 1'b0);
    n = 0;
    while (!out_valid_w[1] && n < 100) begin
      tick();
      n++;
    end
    check("bp_out_valid_rise", 128'(out_valid_w[1]), 128'd1);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        in_state = ALL_63;
        in_valid[1] = 1'b1;
      end else begin
        in_valid[1] = 1'b0;
      end
      tick();
    end
    in_valid[1] = 1'b0;
    check("bp_state_held", out_state_w[1], FIPS_OUT);
    out_ready[1] = 1'b1;
    drain(1);
    repeat (20) tick();

    // Back-to-back with in_valid held high
    b2b_mode = 1'b1;
    send(1, FIPS_IN, FIPS_OUT, 1'b1);
    send(1, ALL_00, ALL_52, 1'b0);
    drain(1);
    send(2, ALL_63, ALL_00, 1'b1);
    send(2, FIPS_IN, FIPS_OUT, 1'b0);
    drain(2);
    b2b_mode = 1'b0;

    // Asynchronous reset while BUSY with grp == 2
    send(1, FIPS_IN, FIPS_OUT, 1'b0);
    tick();
    tick();
    check("midrst_busy_before", 128'(busy_w[1]), 128'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 128'(out_valid_w[1]), 128'd0);
    check("midrst_out_state", out_state_w[1], 128'd0);
    check("midrst_in_ready", 128'(in_ready_w[1]), 128'd1);
    check("midrst_busy", 128'(busy_w[1]), 128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(1, FIPS_IN, FIPS_OUT, 1'b0);
    drain(1);

    // Random states against the reference model with random stalls
    rand_mode = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      send(1, r, ref_model(r), 1'b0);
    end
    rand_mode = 1'b0;
    tick();
    tick();
    out_ready[1] = 1'b1;
    drain(1);
    repeat (20) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
